// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: opcodes, funct3 codes and the stage FSM states.
package mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        GET_INSTR  = 2'd0,
        MEM_ACCESS = 2'd1,
        GIVE_INSTR = 2'd2
    } mem_state_t;

    // Stores only have SB/SH/SW encodings; LHU shares the half-word rule with LH.
    function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (f3 == F3_W)
            mis = (addr_lo != 2'b00);
        else if (f3 == F3_H || (!is_store && f3 == F3_HU))
            mis = addr_lo[0];
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the byte/half lane out of the read word and extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: single-entry load/store stage between EX and WB.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses skip memory and return 0.
//
// state      | meaning
// GET_INSTR  | empty, offering get to EX
// MEM_ACCESS | request held on the data-memory port until ack
// GIVE_INSTR | result valid toward WB until WB takes it
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset_i,
    output logic                 MEM_EX_get_o,
    input  logic                 EX_MEM_give_i,
    input  logic [31:0]          EX_MEM_instruction_i,
    input  logic [BITSIZE-1:0]   EX_MEM_result_i,
    input  logic [BITSIZE-1:0]   EX_MEM_rs2_i,
    input  logic                 WB_MEM_get_i,
    output logic                 MEM_WB_give_o,
    output logic [31:0]          MEM_WB_instruction_o,
    output logic [BITSIZE-1:0]   MEM_WB_data_o,
    output logic                 MEM_req_o,
    output logic                 MEM_we_o,
    output logic [31:0]          MEM_addr_o,
    output logic [BITSIZE/8-1:0] MEM_be_o,
    output logic [BITSIZE-1:0]   MEM_wdata_o,
    input  logic [BITSIZE-1:0]   MEM_rdata_i,
    input  logic                 MEM_ack_i,
    output logic                 misalign_o
);

    mem_state_t         state_q, state_d;
    logic [31:0]        instr_q;
    logic [BITSIZE-1:0] result_q, rs2_q, data_q;
    logic [BITSIZE-1:0] load_data;
    logic               in_mem_op, in_store, in_mis;
    logic               held_load, held_store;
    logic [2:0]         held_f3;

    assign in_mem_op  = (EX_MEM_instruction_i[6:0] == OPC_LOAD) ||
                        (EX_MEM_instruction_i[6:0] == OPC_STORE);
    assign in_store   = (EX_MEM_instruction_i[6:0] == OPC_STORE);
    assign held_load  = (instr_q[6:0] == OPC_LOAD);
    assign held_store = (instr_q[6:0] == OPC_STORE);
    assign held_f3    = instr_q[14:12];

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q;
    assign in_mis = in_mem_op &&
                    is_misaligned(in_store, EX_MEM_instruction_i[14:12], EX_MEM_result_i[1:0]);
    assign misalign_o = misalign_q;

    always_ff @(posedge clk) begin
        if (reset_i)
            misalign_q <= 1'b0;
        else
            misalign_q <= (state_q == GET_INSTR) && EX_MEM_give_i && in_mis;
    end
`else
    assign in_mis     = 1'b0;
    assign misalign_o = 1'b0;
`endif

    mem_load_align u_load_align (
        .rdata   (MEM_rdata_i),
        .addr_lo (result_q[1:0]),
        .funct3  (held_f3),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset_i)
            state_q <= GET_INSTR;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_INSTR:
                if (EX_MEM_give_i)
                    state_d = (in_mem_op && !in_mis) ? MEM_ACCESS : GIVE_INSTR;
            MEM_ACCESS:
                if (MEM_ack_i)
                    state_d = GIVE_INSTR;
            GIVE_INSTR:
                if (WB_MEM_get_i)
                    state_d = GET_INSTR;
            default:
                state_d = GET_INSTR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            instr_q  <= '0;
            result_q <= '0;
            rs2_q    <= '0;
            data_q   <= '0;
        end else begin
            if (state_q == GET_INSTR && EX_MEM_give_i) begin
                instr_q  <= EX_MEM_instruction_i;
                result_q <= EX_MEM_result_i;
                rs2_q    <= EX_MEM_rs2_i;
                data_q   <= in_mis ? '0 : EX_MEM_result_i;
            end else if (state_q == MEM_ACCESS && MEM_ack_i) begin
                data_q   <= held_load ? load_data : result_q;
            end
        end
    end

    // Address/lane outputs come only from held registers, so they stay stable through the request.
    always_comb begin
        MEM_EX_get_o  = (state_q == GET_INSTR);
        MEM_req_o     = (state_q == MEM_ACCESS);
        MEM_WB_give_o = (state_q == GIVE_INSTR);
        MEM_we_o      = (state_q == MEM_ACCESS) && held_store;
        MEM_addr_o    = {result_q[31:2], 2'b00};
        MEM_be_o      = 4'hF;
        MEM_wdata_o   = rs2_q;
        if (held_store) begin
            case (held_f3)
                F3_B: begin
                    MEM_be_o    = 4'b0001 << result_q[1:0];
                    MEM_wdata_o = {4{rs2_q[7:0]}};
                end
                F3_H: begin
                    MEM_be_o    = 4'b0011 << {result_q[1], 1'b0};
                    MEM_wdata_o = {2{rs2_q[15:0]}};
                end
                default: begin
                    MEM_be_o    = 4'hF;
                    MEM_wdata_o = rs2_q;
                end
            endcase
        end
    end

    assign MEM_WB_instruction_o = instr_q;
    assign MEM_WB_data_o        = data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations follow MEM_MISALIGN_CHECK_EN when defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        MEM_EX_get_o;
    logic        EX_MEM_give_i;
    logic [31:0] EX_MEM_instruction_i;
    logic [31:0] EX_MEM_result_i;
    logic [31:0] EX_MEM_rs2_i;
    logic        WB_MEM_get_i;
    logic        MEM_WB_give_o;
    logic [31:0] MEM_WB_instruction_o;
    logic [31:0] MEM_WB_data_o;
    logic        MEM_req_o;
    logic        MEM_we_o;
    logic [31:0] MEM_addr_o;
    logic [3:0]  MEM_be_o;
    logic [31:0] MEM_wdata_o;
    logic [31:0] MEM_rdata_i;
    logic        MEM_ack_i;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LB  = 32'h00008283;
    localparam logic [31:0] I_LBU = 32'h0000C283;
    localparam logic [31:0] I_LH  = 32'h00009283;
    localparam logic [31:0] I_LHU = 32'h0000D283;
    localparam logic [31:0] I_LW  = 32'h0000A283;
    localparam logic [31:0] I_SB  = 32'h00208023;
    localparam logic [31:0] I_SH  = 32'h00209023;

    mem_stage #(.BITSIZE(32)) dut (
        .clk                  (clk),
        .reset_i              (reset_i),
        .MEM_EX_get_o         (MEM_EX_get_o),
        .EX_MEM_give_i        (EX_MEM_give_i),
        .EX_MEM_instruction_i (EX_MEM_instruction_i),
        .EX_MEM_result_i      (EX_MEM_result_i),
        .EX_MEM_rs2_i         (EX_MEM_rs2_i),
        .WB_MEM_get_i         (WB_MEM_get_i),
        .MEM_WB_give_o        (MEM_WB_give_o),
        .MEM_WB_instruction_o (MEM_WB_instruction_o),
        .MEM_WB_data_o        (MEM_WB_data_o),
        .MEM_req_o            (MEM_req_o),
        .MEM_we_o             (MEM_we_o),
        .MEM_addr_o           (MEM_addr_o),
        .MEM_be_o             (MEM_be_o),
        .MEM_wdata_o          (MEM_wdata_o),
        .MEM_rdata_i          (MEM_rdata_i),
        .MEM_ack_i            (MEM_ack_i),
        .misalign_o           (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction while the stage is in GET_INSTR; returns 1ns after the accept edge.
    task automatic offer(input logic [31:0] instr, input logic [31:0] res, input logic [31:0] rs2);
        EX_MEM_give_i        = 1'b1;
        EX_MEM_instruction_i = instr;
        EX_MEM_result_i      = res;
        EX_MEM_rs2_i         = rs2;
        tick();
        EX_MEM_give_i        = 1'b0;
    endtask

    task automatic drain();
        WB_MEM_get_i = 1'b1;
        tick();
        WB_MEM_get_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        n_cmp++; if (MEM_EX_get_o !== 1'b1) begin n_err++; $display("FAIL reset_get: got %b want 1", MEM_EX_get_o); end
        n_cmp++; if ({MEM_req_o, MEM_we_o, MEM_WB_give_o, misalign_o} !== 4'b0000) begin n_err++;
            $display("FAIL reset_ctrl: got %b want 0000", {MEM_req_o, MEM_we_o, MEM_WB_give_o, misalign_o}); end
        n_cmp++; if ({MEM_WB_data_o, MEM_WB_instruction_o} !== 64'h0) begin n_err++;
            $display("FAIL reset_data: got %h/%h want 0/0", MEM_WB_data_o, MEM_WB_instruction_o); end
    endtask

    task automatic test_alu();
        offer(I_ADD, 32'h0000_1234, 32'h0);
        n_cmp++; if ({MEM_WB_give_o, MEM_EX_get_o, MEM_req_o} !== 3'b100) begin n_err++;
            $display("FAIL alu_handshake: got give/get/req %b want 100", {MEM_WB_give_o, MEM_EX_get_o, MEM_req_o}); end
        n_cmp++; if (MEM_WB_data_o !== 32'h0000_1234) begin n_err++; $display("FAIL alu_data: got %h want 00001234", MEM_WB_data_o); end
        n_cmp++; if (MEM_WB_instruction_o !== I_ADD) begin n_err++; $display("FAIL alu_instr: got %h want %h", MEM_WB_instruction_o, I_ADD); end
        drain();
        n_cmp++; if ({MEM_EX_get_o, MEM_WB_give_o} !== 2'b10) begin n_err++;
            $display("FAIL alu_return: got get/give %b want 10", {MEM_EX_get_o, MEM_WB_give_o}); end
    endtask

    task automatic test_load_byte(input logic [31:0] instr, input logic [31:0] exp, input string name);
        offer(instr, 32'h0000_0103, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if ({MEM_req_o, MEM_we_o, MEM_WB_give_o} !== 3'b100) begin n_err++;
                $display("FAIL %s_req%0d: got req/we/give %b want 100", name, i, {MEM_req_o, MEM_we_o, MEM_WB_give_o}); end
            tick();
        end
        n_cmp++; if ({MEM_addr_o, MEM_be_o} !== {32'h0000_0100, 4'hF}) begin n_err++;
            $display("FAIL %s_addr: got %h/%h want 00000100/f", name, MEM_addr_o, MEM_be_o); end
        MEM_ack_i   = 1'b1;
        MEM_rdata_i = 32'h80FF_0000;
        tick();
        MEM_ack_i   = 1'b0;
        MEM_rdata_i = 32'h0;
        n_cmp++; if ({MEM_req_o, MEM_WB_give_o} !== 2'b01) begin n_err++;
            $display("FAIL %s_done: got req/give %b want 01", name, {MEM_req_o, MEM_WB_give_o}); end
        n_cmp++; if (MEM_WB_data_o !== exp) begin n_err++; $display("FAIL %s_data: got %h want %h", name, MEM_WB_data_o, exp); end
        drain();
    endtask

    task automatic test_load_half();
        logic [31:0] exp [2];
        logic [31:0] ins [2];
        exp[0] = 32'hFFFF_80FF; ins[0] = I_LH;
        exp[1] = 32'h0000_80FF; ins[1] = I_LHU;
        for (int i = 0; i < 2; i++) begin
            offer(ins[i], 32'h0000_0102, 32'h0);
            MEM_ack_i   = 1'b1;
            MEM_rdata_i = 32'h80FF_0000;
            tick();
            MEM_ack_i   = 1'b0;
            n_cmp++; if (MEM_WB_data_o !== exp[i]) begin n_err++; $display("FAIL half%0d_data: got %h want %h", i, MEM_WB_data_o, exp[i]); end
            drain();
        end
    endtask

    task automatic test_store_and_stall();
        offer(I_SH, 32'h0000_0102, 32'hDEAD_BEEF);
        n_cmp++; if ({MEM_req_o, MEM_we_o, MEM_be_o} !== 6'b11_1100) begin n_err++;
            $display("FAIL sh_ctrl: got req/we/be %b want 111100", {MEM_req_o, MEM_we_o, MEM_be_o}); end
        n_cmp++; if ({MEM_addr_o, MEM_wdata_o} !== {32'h0000_0100, 32'hBEEF_BEEF}) begin n_err++;
            $display("FAIL sh_bus: got %h/%h want 00000100/beefbeef", MEM_addr_o, MEM_wdata_o); end
        MEM_ack_i = 1'b1;
        tick();
        MEM_ack_i = 1'b0;
        n_cmp++; if ({MEM_req_o, MEM_we_o, MEM_WB_give_o} !== 3'b001) begin n_err++;
            $display("FAIL sh_zero_wait: got req/we/give %b want 001", {MEM_req_o, MEM_we_o, MEM_WB_give_o}); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({MEM_WB_give_o, MEM_EX_get_o, MEM_WB_data_o, MEM_WB_instruction_o} !== {2'b10, 32'h0000_0102, I_SH}) begin n_err++;
                $display("FAIL stall%0d: got give/get %b data %h instr %h want 10 00000102 %h", i,
                         {MEM_WB_give_o, MEM_EX_get_o}, MEM_WB_data_o, MEM_WB_instruction_o, I_SH); end
            tick();
        end
        drain();
        n_cmp++; if ({MEM_WB_give_o, MEM_EX_get_o} !== 2'b01) begin n_err++;
            $display("FAIL stall_xfer: got give/get %b want 01", {MEM_WB_give_o, MEM_EX_get_o}); end
        tick();
        n_cmp++; if (MEM_WB_give_o !== 1'b0) begin n_err++; $display("FAIL stall_once: got give %b want 0", MEM_WB_give_o); end
    endtask

    task automatic test_store_byte();
        offer(I_SB, 32'h0000_0101, 32'h1234_56A5);
        n_cmp++; if ({MEM_be_o, MEM_wdata_o} !== {4'b0010, 32'hA5A5_A5A5}) begin n_err++;
            $display("FAIL sb_lane: got %b/%h want 0010/a5a5a5a5", MEM_be_o, MEM_wdata_o); end
        MEM_ack_i = 1'b1;
        tick();
        MEM_ack_i = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_access();
        offer(I_LW, 32'h0000_0200, 32'h0);
        n_cmp++; if (MEM_req_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_req: got %b want 1", MEM_req_o); end
        reset_i = 1'b1;
        tick();
        reset_i     = 1'b0;
        MEM_ack_i   = 1'b1;
        MEM_rdata_i = 32'hCAFE_F00D;
        n_cmp++; if ({MEM_req_o, MEM_EX_get_o} !== 2'b01) begin n_err++;
            $display("FAIL rst_drop: got req/get %b want 01", {MEM_req_o, MEM_EX_get_o}); end
        tick();
        MEM_ack_i = 1'b0;
        n_cmp++; if ({MEM_req_o, MEM_WB_give_o, MEM_EX_get_o, MEM_WB_data_o} !== {3'b001, 32'h0}) begin n_err++;
            $display("FAIL rst_ack_ignored: got req/give/get %b data %h want 001 0",
                     {MEM_req_o, MEM_WB_give_o, MEM_EX_get_o}, MEM_WB_data_o); end
    endtask

    task automatic test_misalign();
        offer(I_LW, 32'h0000_0101, 32'h0);
`ifdef MEM_MISALIGN_CHECK_EN
        n_cmp++; if ({MEM_req_o, misalign_o, MEM_WB_give_o, MEM_WB_data_o} !== {3'b011, 32'h0}) begin n_err++;
            $display("FAIL mis_on: got req/mis/give %b data %h want 011 0", {MEM_req_o, misalign_o, MEM_WB_give_o}, MEM_WB_data_o); end
        drain();
        n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b want 0", misalign_o); end
`else
        n_cmp++; if ({MEM_req_o, misalign_o, MEM_addr_o} !== {2'b10, 32'h0000_0100}) begin n_err++;
            $display("FAIL mis_off: got req/mis %b addr %h want 10 00000100", {MEM_req_o, misalign_o}, MEM_addr_o); end
        MEM_ack_i   = 1'b1;
        MEM_rdata_i = 32'h1122_3344;
        tick();
        MEM_ack_i   = 1'b0;
        n_cmp++; if (MEM_WB_data_o !== 32'h1122_3344) begin n_err++; $display("FAIL mis_off_data: got %h want 11223344", MEM_WB_data_o); end
        drain();
`endif
    endtask

    initial begin
        reset_i              = 1'b1;
        EX_MEM_give_i        = 1'b0;
        EX_MEM_instruction_i = 32'h0;
        EX_MEM_result_i      = 32'h0;
        EX_MEM_rs2_i         = 32'h0;
        WB_MEM_get_i         = 1'b0;
        MEM_rdata_i          = 32'h0;
        MEM_ack_i            = 1'b0;
        test_reset();
        test_alu();
        test_load_byte(I_LB,  32'hFFFF_FF80, "lb");
        test_load_byte(I_LBU, 32'h0000_0080, "lbu");
        test_load_half();
        test_store_and_stall();
        test_store_byte();
        test_reset_mid_access();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline stage MEM of the in-order RISC-V core. Accepts one instruction at a time from EX, performs its load or store on the data-memory port, and hands the instruction plus result to WB. It is the giving end of the MEM→WB get/give handshake and the getting end of EX→MEM. The stage is unpipelined: it holds at most one instruction.

## Interface
- BITSIZE, 32, datapath width; only 32 is supported (4 byte lanes)
- clk  in  1  clock, all state on rising edge
- reset_i  in  1  synchronous, active-high reset
- MEM_EX_get_o  out  1  stage empty, ready to take from EX
- EX_MEM_give_i  in  1  EX offers an instruction
- EX_MEM_instruction_i  in  32  instruction word
- EX_MEM_result_i  in  BITSIZE  ALU result; the effective address for load/store
- EX_MEM_rs2_i  in  BITSIZE  store data
- WB_MEM_get_i  in  1  WB ready to take
- MEM_WB_give_o  out  1  instruction/data valid toward WB
- MEM_WB_instruction_o  out  32  held instruction
- MEM_WB_data_o  out  BITSIZE  load data, or ALU result for non-memory ops
- MEM_req_o  out  1  memory request
- MEM_we_o  out  1  1 = store
- MEM_addr_o  out  32  word-aligned address (low 2 bits 0)
- MEM_be_o  out  BITSIZE/8  byte enables (stores)
- MEM_wdata_o  out  BITSIZE  lane-replicated store data
- MEM_rdata_i  in  BITSIZE  read word
- MEM_ack_i  in  1  memory completes the request this cycle
- misalign_o  out  1  one-cycle pulse, misaligned access detected

## Operation
- Transfer rule (both handshakes): a transfer occurs on an edge where give and get are both high. Giver holds give and payload stable until that edge.
- States: GET_INSTR, MEM_ACCESS, GIVE_INSTR.
- GET_INSTR: MEM_EX_get_o=1. On EX_MEM_give_i, register instruction, result, and rs2. Opcode LOAD (0000011) or STORE (0100011) → MEM_ACCESS. All other opcodes → GIVE_INSTR, with data = result.
- MEM_ACCESS: MEM_req_o=1, with addr/we/be/wdata stable, until MEM_ack_i. On the ack edge:
  - Load: capture the extracted data.
  - Store: data = result.
  - Go to GIVE_INSTR.
- GIVE_INSTR: MEM_WB_give_o=1. On WB_MEM_get_i → GET_INSTR.
- Load extract, funct3:
  - LB 000 / LBU 100: byte at addr[1:0], sign- or zero-extended.
  - LH 001 / LHU 101: half at addr[1], sign- or zero-extended.
  - LW 010: full word.
  - Other funct3 values are treated as LW.
- Store, funct3:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW (and other values): be=4'hF, wdata=rs2.
  - Loads drive be=4'hF, we=0.
- MEM_ack_i outside MEM_ACCESS is ignored.

## Timing
- Reset (sync, priority over everything): state GET_INSTR; MEM_req_o, MEM_we_o, MEM_WB_give_o, misalign_o = 0; MEM_EX_get_o = 1 in the first cycle after reset. Held registers and data outputs are cleared to 0. Reset during MEM_ACCESS drops the request on the next edge and discards the pending ack.
- Non-memory op: accepted at edge N; give high from N to N+1 at the earliest.
- Memory op: accepted at edge N; req high from N; ack at edge M; give high from M.
- Zero-wait memory (ack in the first req cycle): the req lasts exactly one cycle.
- get and give are never high in the same cycle, so throughput is at most one instruction every 2 cycles.
- Outputs are registered or decoded from state only. No combinational path from EX_MEM_give_i or WB_MEM_get_i to any output.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issues no request.
  - misalign_o pulses for 1 cycle on the edge leaving GET_INSTR.
  - The instruction goes directly to GIVE_INSTR with data 0.
- Macro undefined:
  - misalign_o is tied to 0.
  - Address low bits are ignored, so the access is aligned down.
  - Lanes are still chosen by addr[1:0] per the rules above.

## Structure
- Shared package (with the existing instruction definitions): LOAD/STORE opcodes, funct3 constants, and the mem_state_t enum.
- Sub-module mem_load_align: combinational extract/extend from (rdata, addr[1:0], funct3). Reused by the verification model.

## Test plan
- ADD, result 0x0000_1234 → no MEM_req_o; give with data 0x0000_1234 one cycle after accept; WB get → MEM_EX_get_o high next cycle.
- LB at addr 0x103, rdata 0x80FF_0000, ack after 3 req cycles → data 0xFFFF_FF80. LBU with the same inputs → 0x0000_0080.
- SH at addr 0x102, rs2 0xDEAD_BEEF → be 4'b1100, wdata 0xBEEF_BEEF, addr 0x100, we 1.
- WB get held low for 5 cycles → give and payload stable throughout; exactly one transfer.
- reset_i asserted mid-MEM_ACCESS, then ack the next cycle → req low after the reset edge, no give, state GET_INSTR.
- LW at addr 0x101:
  - Macro on: no req, misalign_o pulse, data 0.
  - Macro off: addr 0x100 requested.
